// File: rtl/sram_pixel_fetch_if.sv
`default_nettype none
// ============================================================================
// sram_pixel_fetch_if : trig/rw/done requester bus toward the byte-wide SRAM controller
// Revision 1.0
// ============================================================================
interface sram_pixel_fetch_if;
    logic        trig_out;
    logic        rw_out;
    logic [18:0] addr_out;
    logic [7:0]  w_data_out;
    logic        done_in;
    logic [7:0]  r_data_in;

    modport master (
        output trig_out, rw_out, addr_out, w_data_out,
        input  done_in, r_data_in
    );

    modport slave (
        input  trig_out, rw_out, addr_out, w_data_out,
        output done_in, r_data_in
    );
endinterface
`default_nettype wire

// File: rtl/sram_pixel_fetch.sv
`default_nettype none
// ============================================================================
// sram_pixel_fetch : streams a linear 8-bit framebuffer from SRAM into a FWFT pixel FIFO, or fills the frame
// Revision 1.0
// ============================================================================
module sram_pixel_fetch #(
    parameter logic [18:0] BASE_ADDR    = 19'h00000,
    parameter int          FRAME_PIXELS = 307200,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          TIMEOUT      = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        frame_start_in,
    input  wire logic        clear_in,
    input  wire logic [7:0]  fill_in,
    input  wire logic        pix_rd_in,
    output logic [7:0]       pix_data_out,
    output logic             pix_valid_out,
    output logic             underflow_out,
    output logic             busy_clear_out,
    output logic             timeout_out,
    sram_pixel_fetch_if.master sram
);
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [WW-1:0] TMO_C    = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            fetch_en, busy, clr_pend, discard, underflow;
    logic [7:0]      fill;
    logic [WW-1:0]   wait_cnt;
    logic            rw_q;
    logic [18:0]     addr_q;
    logic [7:0]      wdata_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;

    logic            fs_acc, clr_accept, start_clear, in_wait, done_seen, tmo, finish;
    logic            wrap, push, pop, space_ok;
    logic [7:0]      start_fill;
    logic [18:0]     req_addr;

    always_comb begin
        fs_acc      = frame_start_in && !busy;
        clr_accept  = clear_in && !busy && !clr_pend;
        start_clear = (state == IDLE) && !busy && (clear_in || clr_pend);
        start_fill  = clr_pend ? fill : fill_in;
        in_wait     = (state == RD_WAIT) || (state == WR_WAIT);
        done_seen   = in_wait && !sram.done_in;
        tmo         = in_wait && sram.done_in && (wait_cnt == TMO_C);
        finish      = done_seen || tmo;
        wrap        = (cnt == LAST_PIX);
        // a read that straddles a frame restart belongs to the old frame
        push        = (state == RD_WAIT) && !sram.done_in && !discard && !fs_acc;
        pop         = pix_rd_in && (count != '0);
        space_ok    = (count < DEPTH_C);
        req_addr    = BASE_ADDR + (start_clear ? 19'd0 : 19'(cnt));
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (busy || start_clear)
                    state_n = WR_REQ;
                else if (fetch_en && !fs_acc && space_ok)
                    state_n = RD_REQ;
            end
            RD_REQ:  state_n = RD_WAIT;
            WR_REQ:  state_n = WR_WAIT;
            RD_WAIT, WR_WAIT: begin
                if (finish)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            fetch_en  <= 1'b0;
            busy      <= 1'b0;
            clr_pend  <= 1'b0;
            discard   <= 1'b0;
            underflow <= 1'b0;
            fill      <= 8'h00;
            wait_cnt  <= '0;
            rw_q      <= 1'b1;
            addr_q    <= 19'd0;
            wdata_q   <= 8'h00;
        end else begin
            if ((state == IDLE) && (state_n != IDLE)) begin
                rw_q   <= (state_n == RD_REQ);
                addr_q <= req_addr;
                if (state_n == WR_REQ)
                    wdata_q <= start_clear ? start_fill : fill;
            end

            if ((state == RD_REQ) || (state == WR_REQ))
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + WW'(1);

            if (clr_accept)
                fill <= fill_in;

            if (start_clear)
                clr_pend <= 1'b0;
            else if (clr_accept)
                clr_pend <= 1'b1;

            if (start_clear)
                busy <= 1'b1;
            else if (finish && (state == WR_WAIT) && wrap)
                busy <= 1'b0;

            // timed-out accesses still advance: the pixel is skipped, not retried
            if (start_clear || fs_acc)
                cnt <= '0;
            else if (finish && !discard)
                cnt <= wrap ? '0 : cnt + CW'(1);

            if (fs_acc)
                fetch_en <= 1'b1;
            else if (finish && (state == RD_WAIT) && !discard && wrap)
                fetch_en <= 1'b0;

            if (finish)
                discard <= 1'b0;
            else if (fs_acc && ((state == RD_REQ) || (state == RD_WAIT)))
                discard <= 1'b1;

            if (fs_acc)
                underflow <= 1'b0;
            else if (pix_rd_in && (count == '0))
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fs_acc) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW + 1)'(1);
            else if (!push && pop)
                count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sram.r_data_in;
    end

    assign sram.trig_out   = (state == RD_REQ) || (state == WR_REQ);
    assign sram.rw_out     = rw_q;
    assign sram.addr_out   = addr_q;
    assign sram.w_data_out = wdata_q;

    assign pix_valid_out  = (count != '0);
    assign pix_data_out   = pix_valid_out ? mem[rd_ptr] : 8'h00;
    assign underflow_out  = underflow;
    assign busy_clear_out = busy;
    assign timeout_out    = tmo;
endmodule
`default_nettype wire

// File: tb/tb_sram_pixel_fetch.sv
`default_nettype none
// ============================================================================
// tb_sram_pixel_fetch : directed bench with a small SRAM controller model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sram_pixel_fetch;
    localparam int FP    = 20;
    localparam int TO    = 15;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start_in = 1'b0;
    logic       clear_in = 1'b0;
    logic [7:0] fill_in = 8'h00;
    logic       pix_rd_in = 1'b0;
    logic [7:0] pix_data_out;
    logic       pix_valid_out, underflow_out, busy_clear_out, timeout_out;

    sram_pixel_fetch_if sram_bus ();

    sram_pixel_fetch #(
        .BASE_ADDR    (19'h00000),
        .FRAME_PIXELS (FP),
        .FIFO_DEPTH   (DEPTH),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start_in (frame_start_in),
        .clear_in       (clear_in),
        .fill_in        (fill_in),
        .pix_rd_in      (pix_rd_in),
        .pix_data_out   (pix_data_out),
        .pix_valid_out  (pix_valid_out),
        .underflow_out  (underflow_out),
        .busy_clear_out (busy_clear_out),
        .timeout_out    (timeout_out),
        .sram           (sram_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // controller model: done_in low for one cycle, two cycles after the trig cycle
    int          ntrig = 0;
    int          b2b = 0;
    int          pending = 0;
    bit          hang = 1'b0;
    logic        prev_trig = 1'b0;
    logic [7:0]  pend_data = 8'h00;
    logic [18:0] t_addr [$];
    logic        t_rw   [$];
    logic [7:0]  t_wd   [$];

    initial begin
        sram_bus.done_in   = 1'b1;
        sram_bus.r_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending          = 0;
                prev_trig        = 1'b0;
                sram_bus.done_in = 1'b1;
            end else begin
                sram_bus.done_in = 1'b1;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        sram_bus.done_in   = 1'b0;
                        sram_bus.r_data_in = pend_data;
                    end
                end
                if (sram_bus.trig_out) begin
                    if (prev_trig)
                        b2b++;
                    t_addr.push_back(sram_bus.addr_out);
                    t_rw.push_back(sram_bus.rw_out);
                    t_wd.push_back(sram_bus.w_data_out);
                    ntrig++;
                    if (!hang) begin
                        pending   = 2;
                        pend_data = sram_bus.addr_out[7:0];
                    end
                end
                prev_trig = sram_bus.trig_out;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rec_addr(input int idx);
        if (idx < t_addr.size()) return 32'(t_addr[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rec_rwwd(input int idx);
        if (idx < t_rw.size()) return {23'd0, t_rw[idx], t_wd[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, " trig"},      32'(sram_bus.trig_out),   32'd0);
        chk({tag, " rw"},        32'(sram_bus.rw_out),     32'd1);
        chk({tag, " addr"},      32'(sram_bus.addr_out),   32'd0);
        chk({tag, " wdata"},     32'(sram_bus.w_data_out), 32'd0);
        chk({tag, " valid"},     32'(pix_valid_out),       32'd0);
        chk({tag, " data"},      32'(pix_data_out),        32'd0);
        chk({tag, " underflow"}, 32'(underflow_out),       32'd0);
        chk({tag, " busy"},      32'(busy_clear_out),      32'd0);
        chk({tag, " timeout"},   32'(timeout_out),         32'd0);
    endtask

    task automatic pulse_frame_start();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    typedef struct {
        logic       pop;
        logic       valid;
        logic [7:0] data;
        logic       uf;
    } vec_t;

    vec_t tbl [23];

    initial begin : main
        int base;
        int cbase;
        int n;
        int d;
        logic seen_busy;

        for (int i = 0; i < FP; i++)
            tbl[i] = '{pop: 1'b1, valid: 1'b1, data: 8'(i), uf: 1'b0};
        tbl[20] = '{pop: 1'b1, valid: 1'b0, data: 8'h00, uf: 1'b0};
        tbl[21] = '{pop: 1'b0, valid: 1'b0, data: 8'h00, uf: 1'b1};
        tbl[22] = '{pop: 1'b0, valid: 1'b0, data: 8'h00, uf: 1'b1};

        // reset, then reset again in the middle of a read wait
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset("reset");
        pulse_frame_start();
        n = 0;
        while (!sram_bus.trig_out && n < 20) begin tick(); n++; end
        chk("first trig seen", 32'(sram_bus.trig_out), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check_reset("async reset");
        tick();
        tick();
        rst = 1'b1;
        base = ntrig;
        repeat (12) tick();
        chk("no trig after reset", ntrig - base, 0);
        check_reset("post reset");

        // fill: 16 reads then stall
        base = ntrig;
        pulse_frame_start();
        repeat (120) tick();
        chk("reads issued", ntrig - base, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("read addr", rec_addr(base + i), 32'(i));
            chk("read rw",   rec_rwwd(base + i) >> 8, 32'd1);
        end
        repeat (20) tick();
        chk("fetch stalled", ntrig - base, DEPTH);

        // drain with one pop per cycle, then pop into an empty FIFO
        for (int i = 0; i < 23; i++) begin
            chk("pix valid",     32'(pix_valid_out), 32'(tbl[i].valid));
            chk("pix data",      32'(pix_data_out),  32'(tbl[i].data));
            chk("underflow",     32'(underflow_out), 32'(tbl[i].uf));
            pix_rd_in = tbl[i].pop;
            tick();
        end
        pix_rd_in = 1'b0;
        repeat (20) tick();
        chk("frame read count", ntrig - base, FP);
        chk("underflow sticky", 32'(underflow_out), 32'd1);

        // clear issued while a read is outstanding
        pulse_frame_start();
        chk("underflow cleared", 32'(underflow_out), 32'd0);
        n = 0;
        while (!sram_bus.trig_out && n < 20) begin tick(); n++; end
        chk("read before clear", 32'(sram_bus.trig_out), 32'd1);
        cbase     = ntrig;
        clear_in  = 1'b1;
        fill_in   = 8'hA5;
        tick();
        clear_in  = 1'b0;
        fill_in   = 8'h3C;
        n = 0;
        while (!busy_clear_out && n < 10) begin tick(); n++; end
        seen_busy = busy_clear_out;
        chk("busy rises", 32'(seen_busy), 32'd1);
        n = 0;
        while (busy_clear_out && n < 300) begin tick(); n++; end
        chk("busy falls", 32'(busy_clear_out), 32'd0);
        for (int i = 0; i < FP; i++) begin
            chk("clear wr addr",    rec_addr(cbase + i), 32'(i));
            chk("clear wr rw/data", rec_rwwd(cbase + i), 32'h0A5);
        end

        // controller never completes: timeout and skip
        repeat (100) tick();
        hang = 1'b1;
        base = ntrig;
        pulse_frame_start();
        n = 0;
        while (!sram_bus.trig_out && n < 20) begin tick(); n++; end
        chk("hang trig", 32'(sram_bus.trig_out), 32'd1);
        chk("hang trig addr", 32'(sram_bus.addr_out), 32'd0);
        d = 0;
        while (!timeout_out && d < 40) begin tick(); d++; end
        chk("timeout latency", d, TO + 1);
        chk("fifo unchanged at timeout", 32'(pix_valid_out), 32'd0);
        hang = 1'b0;
        tick();
        chk("timeout one cycle", 32'(timeout_out), 32'd0);
        n = 0;
        while (!sram_bus.trig_out && n < 20) begin tick(); n++; end
        chk("addr after timeout", 32'(sram_bus.addr_out), 32'd1);
        n = 0;
        while (!pix_valid_out && n < 20) begin tick(); n++; end
        chk("pixel after timeout", 32'(pix_data_out), 32'd1);

        chk("no back-to-back trig", b2b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
